cpu_sequencer: RTL and testbench



---
 rtl/cpu_sequencer.sv | 168 ++++++++++++++++
 tb/tb_cpu_sequencer.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_sequencer
//  Brief    : Multi-cycle fetch/decode/execute control unit for the 4-bit
//             accumulator CPU (PC, IR, imem handshake, A-write/ALU controls).
//  Revision : 1.0  initial release
// ============================================================================
module cpu_sequencer #(
  parameter int PCW     = 4,
  parameter int IW      = 4,
  parameter int TIMEOUT = 15,
  parameter int RCW     = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           run,
  input  logic           step,
  output logic           imem_req,
  output logic [PCW-1:0] imem_addr,
  input  logic           imem_ack,
  input  logic [IW-1:0]  imem_rdata,
  output logic           a_we,
  output logic [2:0]     alu_op,
  output logic           alu_b,
  output logic [PCW-1:0] pc,
  output logic [IW-1:0]  ir,
  output logic           busy,
  output logic           halted,
  output logic           fault,
  output logic [RCW-1:0] retired
);

  localparam int         WCW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [2:0] OP_JMP = 3'b110;
  localparam logic [2:0] OP_HLT = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_HALT  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t         state_q;
  logic [PCW-1:0] pc_q;
  logic [IW-1:0]  ir_q;
  logic           req_q;
  logic           awe_q;
  logic [2:0]     aluop_q;
  logic           alub_q;
  logic           busy_q;
  logic           halted_q;
  logic           fault_q;
  logic [RCW-1:0] retired_q;
  logic [WCW-1:0] wcnt_q;
  logic           oneshot_q;

  logic [2:0]     opcode;
  logic [2:0]     fetch_op;
  logic [PCW-1:0] pc_d;
  logic [RCW-1:0] retired_d;

  always_comb begin
    opcode    = ir_q[IW-1:IW-3];
    fetch_op  = imem_rdata[IW-1:IW-3];
    if (opcode == OP_JMP) begin
      pc_d = {{(PCW-1){1'b0}}, ir_q[0]};
    end else begin
      pc_d = pc_q + PCW'(1);
    end
    retired_d = (&retired_q) ? retired_q : retired_q + RCW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      req_q     <= 1'b0;
      awe_q     <= 1'b0;
      aluop_q   <= 3'b000;
      alub_q    <= 1'b0;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
      fault_q   <= 1'b0;
      retired_q <= '0;
      wcnt_q    <= '0;
      oneshot_q <= 1'b0;
    end else begin
      awe_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (run || step) begin
            state_q   <= S_FETCH;
            req_q     <= 1'b1;
            busy_q    <= 1'b1;
            wcnt_q    <= '0;
            oneshot_q <= !run;
          end
        end

        S_FETCH: begin
          if (imem_ack) begin
            ir_q    <= imem_rdata;
            req_q   <= 1'b0;
            state_q <= S_EXEC;
            // ALU controls are set up one edge early so they are registered in EXEC
            if (fetch_op < OP_JMP) begin
              awe_q   <= 1'b1;
              aluop_q <= fetch_op;
              alub_q  <= imem_rdata[0];
            end
          end else if (wcnt_q == WCW'(TIMEOUT)) begin
            state_q <= S_FAULT;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            fault_q <= 1'b1;
          end else begin
            wcnt_q <= wcnt_q + WCW'(1);
          end
        end

        S_EXEC: begin
          pc_q      <= pc_d;
          retired_q <= retired_d;
          if (opcode == OP_HLT) begin
            state_q  <= S_HALT;
            busy_q   <= 1'b0;
            halted_q <= 1'b1;
          end else if (run && !oneshot_q) begin
            state_q <= S_FETCH;
            req_q   <= 1'b1;
            wcnt_q  <= '0;
          end else begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            oneshot_q <= 1'b0;
          end
        end

        S_HALT, S_FAULT: begin
          state_q <= state_q;
        end

        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign a_we      = awe_q;
  assign alu_op    = aluop_q;
  assign alu_b     = alub_q;
  assign pc        = pc_q;
  assign ir        = ir_q;
  assign busy      = busy_q;
  assign halted    = halted_q;
  assign fault     = fault_q;
  assign retired   = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu_sequencer
//  Brief    : Self-checking bench for cpu_sequencer with an ALU-write scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cpu_sequencer;

  localparam int PCW     = 4;
  localparam int IW      = 4;
  localparam int TIMEOUT = 15;
  localparam int RCW     = 8;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           run = 1'b0;
  logic           step = 1'b0;
  logic           imem_req;
  logic [PCW-1:0] imem_addr;
  logic           imem_ack = 1'b0;
  logic [IW-1:0]  imem_rdata = '0;
  logic           a_we;
  logic [2:0]     alu_op;
  logic           alu_b;
  logic [PCW-1:0] pc;
  logic [IW-1:0]  ir;
  logic           busy;
  logic           halted;
  logic           fault;
  logic [RCW-1:0] retired;

  logic [IW-1:0]  mem [16];
  int             ack_delay = 0;
  bit             no_ack = 1'b0;
  int             k = 0;

  int             errors = 0;
  int             checks = 0;
  logic [3:0]     sb [$];

  cpu_sequencer #(.PCW(PCW), .IW(IW), .TIMEOUT(TIMEOUT), .RCW(RCW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .run       (run),
    .step      (step),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata),
    .a_we      (a_we),
    .alu_op    (alu_op),
    .alu_b     (alu_b),
    .pc        (pc),
    .ir        (ir),
    .busy      (busy),
    .halted    (halted),
    .fault     (fault),
    .retired   (retired)
  );

  always #5 clk = ~clk;

  // Memory model: acks on fetch cycle index ack_delay, counted per request
  always @(negedge clk) begin
    if (imem_req) begin
      imem_ack   = !no_ack && (k == ack_delay);
      imem_rdata = mem[imem_addr];
      k          = k + 1;
    end else begin
      imem_ack = 1'b0;
      k        = 0;
    end
  end

  // Scoreboard: every A-register write must match the next expected entry
  always @(negedge clk) begin
    if (reset_n && a_we) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_awe: got op=%b b=%b, required no write", alu_op, alu_b);
      end else begin
        logic [3:0] exp_w;
        exp_w = sb.pop_front();
        if ({alu_op, alu_b} !== exp_w) begin
          errors++;
          $display("FAIL sb_awe_ctrl: got op=%b b=%b, required op=%b b=%b",
                   alu_op, alu_b, exp_w[3:1], exp_w[0]);
        end
      end
    end
  end

  task automatic do_reset();
    reset_n = 1'b0;
    run     = 1'b0;
    step    = 1'b0;
    no_ack  = 1'b0;
    ack_delay = 0;
    for (int i = 0; i < 16; i++) mem[i] = 4'h0;
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #1;
    checks++;
    if ({imem_req, a_we, busy, halted, fault} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got req/awe/busy/halt/fault=%b, required 00000",
               {imem_req, a_we, busy, halted, fault});
    end
    checks++;
    if ({pc, ir, imem_addr} !== '0) begin
      errors++;
      $display("FAIL reset_regs: got pc=%0d ir=%h addr=%0d, required 0", pc, ir, imem_addr);
    end
    checks++;
    if ({alu_op, alu_b, retired} !== '0) begin
      errors++;
      $display("FAIL reset_alu_ret: got op=%b b=%b retired=%0d, required 0", alu_op, alu_b, retired);
    end
  endtask

  task automatic test_program();
    int awe_mask;
    int halt_cycle;
    int req_after;
    do_reset();
    mem[0] = 4'h1; mem[1] = 4'h3; mem[2] = 4'hE;
    sb.push_back({3'b000, 1'b1});
    sb.push_back({3'b001, 1'b1});
    run = 1'b1;
    awe_mask = 0; halt_cycle = -1; req_after = 0;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      if (a_we) awe_mask = awe_mask | (1 << i);
      if (halted && halt_cycle < 0) halt_cycle = i;
      if (halted && imem_req) req_after++;
    end
    checks++;
    if (awe_mask !== 32'h14) begin
      errors++;
      $display("FAIL prog_awe_cycles: got mask=%h, required 14", awe_mask);
    end
    checks++;
    if (halt_cycle !== 7) begin
      errors++;
      $display("FAIL prog_halt_cycle: got %0d, required 7", halt_cycle);
    end
    checks++;
    if (pc !== 4'd3 || retired !== 8'd3 || busy !== 1'b0) begin
      errors++;
      $display("FAIL prog_final: got pc=%0d retired=%0d busy=%b, required 3 3 0", pc, retired, busy);
    end
    checks++;
    if (req_after !== 0) begin
      errors++;
      $display("FAIL prog_req_after_halt: got %0d, required 0", req_after);
    end
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL prog_sb_left: got %0d pending, required 0", sb.size());
    end
    @(negedge clk); run = 1'b0;
  endtask

  task automatic test_jmp();
    int addr_err;
    int ret_err;
    int awe_cnt;
    int nfetch;
    do_reset();
    mem[0] = 4'hD; mem[1] = 4'hC;
    run = 1'b1;
    addr_err = 0; ret_err = 0; awe_cnt = 0; nfetch = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (imem_req) begin
        if (imem_addr !== PCW'(nfetch % 2)) addr_err++;
        nfetch++;
      end
      if (a_we) awe_cnt++;
      if (retired !== RCW'((i - 1) / 2)) ret_err++;
    end
    checks++;
    if (nfetch !== 10 || addr_err !== 0) begin
      errors++;
      $display("FAIL jmp_fetch_seq: got fetches=%0d bad_addr=%0d, required 10 0", nfetch, addr_err);
    end
    checks++;
    if (awe_cnt !== 0) begin
      errors++;
      $display("FAIL jmp_awe: got %0d writes, required 0", awe_cnt);
    end
    checks++;
    if (ret_err !== 0) begin
      errors++;
      $display("FAIL jmp_retired_rate: got %0d bad samples, required 0", ret_err);
    end
    @(negedge clk); run = 1'b0;
    repeat (3) @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || pc !== 4'd0 || retired !== 8'd10) begin
      errors++;
      $display("FAIL jmp_stop: got busy=%b pc=%0d retired=%0d, required 0 0 10", busy, pc, retired);
    end
  endtask

  task automatic test_step();
    int awe_cnt;
    int req_cnt;
    logic busy3;
    do_reset();
    mem[0] = 4'h5;
    sb.push_back({3'b010, 1'b1});
    step = 1'b1;
    awe_cnt = 0; req_cnt = 0; busy3 = 1'bx;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (a_we) awe_cnt++;
      if (imem_req) req_cnt++;
      if (i == 3) busy3 = busy;
      @(negedge clk);
      step = (i == 2);
    end
    checks++;
    if (awe_cnt !== 1 || req_cnt !== 1) begin
      errors++;
      $display("FAIL step_once: got writes=%0d fetch_cycles=%0d, required 1 1", awe_cnt, req_cnt);
    end
    checks++;
    if (busy3 !== 1'b0 || busy !== 1'b0 || pc !== 4'd1 || retired !== 8'd1) begin
      errors++;
      $display("FAIL step_idle: got busy3=%b busy=%b pc=%0d retired=%0d, required 0 0 1 1",
               busy3, busy, pc, retired);
    end
  endtask

  task automatic test_delay();
    int req_cnt;
    int addr_err;
    int awe_cycle;
    do_reset();
    mem[0] = 4'h1;
    ack_delay = 5;
    sb.push_back({3'b000, 1'b1});
    step = 1'b1;
    req_cnt = 0; addr_err = 0; awe_cycle = -1;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (imem_req) begin
        req_cnt++;
        if (imem_addr !== 4'd0) addr_err++;
      end
      if (a_we) awe_cycle = i;
      @(negedge clk);
      step = 1'b0;
    end
    checks++;
    if (req_cnt !== 6 || addr_err !== 0) begin
      errors++;
      $display("FAIL delay_req_hold: got req_cycles=%0d bad_addr=%0d, required 6 0", req_cnt, addr_err);
    end
    checks++;
    if (awe_cycle !== 7 || pc !== 4'd1 || fault !== 1'b0) begin
      errors++;
      $display("FAIL delay_exec: got awe_cycle=%0d pc=%0d fault=%b, required 7 1 0", awe_cycle, pc, fault);
    end
  endtask

  task automatic test_timeout();
    int req_cnt;
    int fault_cycle;
    do_reset();
    no_ack = 1'b1;
    run = 1'b1;
    req_cnt = 0; fault_cycle = -1;
    for (int i = 1; i <= 24; i++) begin
      @(posedge clk); #1;
      if (imem_req) req_cnt++;
      if (fault && fault_cycle < 0) fault_cycle = i;
    end
    checks++;
    if (req_cnt !== 16 || fault_cycle !== 17) begin
      errors++;
      $display("FAIL timeout_fault: got req_cycles=%0d fault_cycle=%0d, required 16 17", req_cnt, fault_cycle);
    end
    checks++;
    if (fault !== 1'b1 || imem_req !== 1'b0 || busy !== 1'b0 || pc !== 4'd0 || retired !== 8'd0) begin
      errors++;
      $display("FAIL timeout_state: got fault=%b req=%b busy=%b pc=%0d retired=%0d, required 1 0 0 0 0",
               fault, imem_req, busy, pc, retired);
    end
    @(negedge clk); run = 1'b0; no_ack = 1'b0;
  endtask

  task automatic test_wrap_saturate();
    int n;
    int pc_err;
    logic [PCW-1:0] pc15;
    logic [PCW-1:0] pc16;
    logic [RCW-1:0] ret254;
    logic [RCW-1:0] ret299;
    do_reset();
    for (int i = 0; i < 16; i++) mem[i] = 4'h1;
    for (int i = 0; i < 300; i++) sb.push_back({3'b000, 1'b1});
    run = 1'b1;
    n = 0; pc_err = 0; pc15 = 'x; pc16 = 'x; ret254 = 'x; ret299 = 'x;
    for (int i = 0; i < 1000 && n < 300; i++) begin
      @(posedge clk); #1;
      if (a_we) begin
        if (pc !== PCW'(n % 16)) pc_err++;
        if (n == 15) pc15 = pc;
        if (n == 16) pc16 = pc;
        if (n == 254) ret254 = retired;
        if (n == 299) ret299 = retired;
        n++;
        if (n == 300) begin
          @(negedge clk);
          run = 1'b0;
        end
      end
    end
    repeat (3) @(posedge clk); #1;
    checks++;
    if (n !== 300 || pc_err !== 0 || pc15 !== 4'd15 || pc16 !== 4'd0) begin
      errors++;
      $display("FAIL wrap_pc: got n=%0d bad_pc=%0d pc15=%0d pc16=%0d, required 300 0 15 0",
               n, pc_err, pc15, pc16);
    end
    checks++;
    if (ret254 !== 8'd254 || ret299 !== 8'd255 || retired !== 8'd255) begin
      errors++;
      $display("FAIL sat_retired: got r254=%0d r299=%0d final=%0d, required 254 255 255",
               ret254, ret299, retired);
    end
    checks++;
    if (pc !== 4'd12 || busy !== 1'b0 || sb.size() !== 0) begin
      errors++;
      $display("FAIL wrap_final: got pc=%0d busy=%b pending=%0d, required 12 0 0", pc, busy, sb.size());
    end
  endtask

  task automatic test_async_reset();
    int awe_cnt;
    do_reset();
    for (int i = 0; i < 16; i++) mem[i] = 4'h1;
    sb.push_back({3'b000, 1'b1});
    sb.push_back({3'b000, 1'b1});
    run = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (imem_req !== 1'b1 || pc !== 4'd2 || retired !== 8'd2 || busy !== 1'b1) begin
      errors++;
      $display("FAIL arst_pre: got req=%b pc=%0d retired=%0d busy=%b, required 1 2 2 1",
               imem_req, pc, retired, busy);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || pc !== 4'd0 || retired !== 8'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL arst_immediate: got req=%b pc=%0d retired=%0d busy=%b, required 0 0 0 0",
               imem_req, pc, retired, busy);
    end
    @(negedge clk);
    reset_n = 1'b1;
    sb.push_back({3'b000, 1'b1});
    sb.push_back({3'b000, 1'b1});
    awe_cnt = 0;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      if (a_we) awe_cnt++;
    end
    @(negedge clk); run = 1'b0;
    repeat (2) @(posedge clk); #1;
    checks++;
    if (awe_cnt !== 2 || pc !== 4'd2 || retired !== 8'd2 || busy !== 1'b0 || sb.size() !== 0) begin
      errors++;
      $display("FAIL arst_resume: got writes=%0d pc=%0d retired=%0d busy=%b pending=%0d, required 2 2 2 0 0",
               awe_cnt, pc, retired, busy, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_program();
    test_jmp();
    test_step();
    test_delay();
    test_timeout();
    test_wrap_saturate();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
